// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared encodings, FSM states and op decode helpers for div_seq
package div_seq_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int TAG_W_DEF = 5;

  // op_sel encodings (funct3[1:0] of the RV32M divide group)
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPECIAL = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] sel);
    return (sel == OP_DIV) || (sel == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] sel);
    return (sel == OP_REM) || (sel == OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negate of a W-bit value
module div_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_value,
  input  logic         i_neg,
  output logic [W-1:0] o_value
);

  // Negating the most negative value wraps to itself, which is exactly the magnitude we want.
  assign o_value = i_neg ? (~i_value + {{(W-1){1'b0}}, 1'b1}) : i_value;

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - RV32M divide sequencer in front of an unsigned iterative divider (optional DIV_SEQ_FLUSH_EN adds flush_in)
module div_seq
  import div_seq_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
`ifdef DIV_SEQ_FLUSH_EN
  input  logic             flush_in,
`endif
  input  logic             op_valid_in,
  output logic             op_ready_out,
  input  logic [1:0]       op_sel_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic [TAG_W-1:0] rd_in,
  output logic             res_valid_out,
  input  logic             res_ready_in,
  output logic [XLEN-1:0]  res_data_out,
  output logic [TAG_W-1:0] res_rd_out,
  output logic             busy_out,
  output logic             div_req_out,
  output logic             div_is_q_out,
  output logic [XLEN-1:0]  div_dividend_out,
  output logic [XLEN-1:0]  div_divitor_out,
  input  logic             div_ready_in,
  input  logic [XLEN-1:0]  div_result_in
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_is_rem;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;
  logic [XLEN-1:0]  r_dividend;
  logic [XLEN-1:0]  r_divisor;
  logic [TAG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_res;

  logic             w_flush;
  logic             w_signed;
  logic             w_s1;
  logic             w_s2;
  logic             w_dz;
  logic             w_ovf;
  logic             w_accept;
  logic             w_load_res;
  logic             w_res_neg;
  logic [XLEN-1:0]  w_abs1;
  logic [XLEN-1:0]  w_abs2;
  logic [XLEN-1:0]  w_raw;
  logic [XLEN-1:0]  w_res;

`ifdef DIV_SEQ_FLUSH_EN
  assign w_flush = flush_in;
`else
  assign w_flush = 1'b0;
`endif

  assign w_signed = op_is_signed(op_sel_in);
  assign w_s1     = w_signed & rs1_in[XLEN-1];
  assign w_s2     = w_signed & rs2_in[XLEN-1];
  assign w_dz     = (rs2_in == '0);
  assign w_ovf    = w_signed & (rs1_in == MIN_NEG) & (rs2_in == '1);
  assign w_accept = (r_state == ST_IDLE) & op_valid_in & ~w_flush;

  div_sign_fix #(.W(XLEN)) u_abs_rs1 (.i_value(rs1_in), .i_neg(w_s1), .o_value(w_abs1));
  div_sign_fix #(.W(XLEN)) u_abs_rs2 (.i_value(rs2_in), .i_neg(w_s2), .o_value(w_abs2));

  // Pre-sign result: divider output, or the special-case magnitude. Div-by-zero remainder is the
  // dividend magnitude re-signed by neg_r, which recovers rs1 exactly.
  always_comb begin
    w_raw = div_result_in;
    if (r_state == ST_SPECIAL) begin
      if (r_is_rem) w_raw = r_dz ? r_dividend : '0;
      else          w_raw = r_dz ? '1 : MIN_NEG;
    end
  end

  assign w_res_neg  = r_is_rem ? r_neg_r : r_neg_q;
  assign w_load_res = ~w_flush & ((r_state == ST_SPECIAL) | ((r_state == ST_WAIT) & div_ready_in));

  div_sign_fix #(.W(XLEN)) u_fix_res (.i_value(w_raw), .i_neg(w_res_neg), .o_value(w_res));

  // State register
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt   = r_state;
    op_ready_out  = 1'b0;
    res_valid_out = 1'b0;
    busy_out      = 1'b1;
    div_req_out   = 1'b0;
    div_is_q_out  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        op_ready_out = 1'b1;
        busy_out     = 1'b0;
        if (w_accept) w_state_nxt = (w_dz | w_ovf) ? ST_SPECIAL : ST_WAIT;
      end
      ST_SPECIAL: w_state_nxt = ST_RESP;
      ST_WAIT: begin
        div_req_out  = 1'b1;
        div_is_q_out = r_is_rem;
        if (div_ready_in) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        res_valid_out = 1'b1;
        if (res_ready_in) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_flush && (r_state != ST_IDLE)) w_state_nxt = ST_IDLE;
  end

  // Operand/sign capture on accept, result capture when it becomes known
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_is_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rd       <= '0;
      r_res      <= '0;
    end else begin
      if (w_accept) begin
        r_is_rem   <= op_is_rem(op_sel_in);
        r_neg_q    <= w_signed & (rs1_in[XLEN-1] ^ rs2_in[XLEN-1]) & ~w_dz;
        r_neg_r    <= w_s1;
        r_dz       <= w_dz;
        r_dividend <= w_abs1;
        r_divisor  <= w_abs2;
        r_rd       <= rd_in;
      end
      if (w_load_res) r_res <= w_res;
    end
  end

  assign res_data_out     = r_res;
  assign res_rd_out       = r_rd;
  assign div_dividend_out = r_dividend;
  assign div_divitor_out  = r_divisor;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - scoreboard bench for div_seq with a behavioural divider and RV32M reference model
module tb_div_seq;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
  } exp_t;

  logic        clk;
  logic        reset_n_in;
`ifdef DIV_SEQ_FLUSH_EN
  logic        flush_in;
`endif
  logic        op_valid_in;
  logic        op_ready_out;
  logic [1:0]  op_sel_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic [4:0]  rd_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic [31:0] res_data_out;
  logic [4:0]  res_rd_out;
  logic        busy_out;
  logic        div_req_out;
  logic        div_is_q_out;
  logic [31:0] div_dividend_out;
  logic [31:0] div_divitor_out;
  logic        div_ready_in;
  logic [31:0] div_result_in;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   bp = 0;
  bit   spur_en = 0;
  int   fixed_lat = 0;

  div_seq dut (
    .clk_in(clk),
    .reset_n_in(reset_n_in),
`ifdef DIV_SEQ_FLUSH_EN
    .flush_in(flush_in),
`endif
    .op_valid_in(op_valid_in),
    .op_ready_out(op_ready_out),
    .op_sel_in(op_sel_in),
    .rs1_in(rs1_in),
    .rs2_in(rs2_in),
    .rd_in(rd_in),
    .res_valid_out(res_valid_out),
    .res_ready_in(res_ready_in),
    .res_data_out(res_data_out),
    .res_rd_out(res_rd_out),
    .busy_out(busy_out),
    .div_req_out(div_req_out),
    .div_is_q_out(div_is_q_out),
    .div_dividend_out(div_dividend_out),
    .div_divitor_out(div_divitor_out),
    .div_ready_in(div_ready_in),
    .div_result_in(div_result_in)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // RISC-V M-extension semantics written directly from the ISA rules
  function automatic logic [31:0] ref_div(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    case (s)
      DIV:  if (b == 0) return 32'hFFFFFFFF;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            else return 32'(sa / sbv);
      DIVU: return (b == 0) ? 32'hFFFFFFFF : a / b;
      REM:  if (b == 0) return a;
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
            else return 32'(sa % sbv);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  // Caller is at posedge+#1; returns at accept edge +#1
  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int g = 0;
    while (!op_ready_out && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!op_ready_out) fail_now("issue_timeout");
    op_valid_in = 1;
    op_sel_in = s;
    rs1_in = a;
    rs2_in = b;
    rd_in = t;
    sb.push_back('{data: ref_div(s, a, b), rd: t});
    @(posedge clk); #1;
    op_valid_in = 0;
    rs1_in = $urandom;
    rs2_in = $urandom;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((sb.size() != 0 || busy_out) && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0 || busy_out) fail_now("drain_timeout");
  endtask

  task automatic special_issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    issue(s, a, b, t);
    check("special_valid_c1", 32'(res_valid_out), 32'h0);
    check("special_req_c1", 32'(div_req_out), 32'h0);
    @(posedge clk); #1;
    check("special_valid_c2", 32'(res_valid_out), 32'h1);
    check("special_req_c2", 32'(div_req_out), 32'h0);
  endtask

  // Writeback ready driver
  initial begin
    res_ready_in = 0;
    forever begin
      @(posedge clk); #1;
      res_ready_in = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Behavioural unsigned divider with random latency and optional stray ready pulses
  initial begin
    int cnt;
    bit real_pulse;
    cnt = -1;
    real_pulse = 0;
    div_ready_in = 0;
    div_result_in = 0;
    forever begin
      @(negedge clk);
      if (div_ready_in) begin
        div_ready_in = 0;
        if (real_pulse) check("div_req_drop", 32'(div_req_out), 32'h0);
        real_pulse = 0;
        cnt = -1;
      end else if (!div_req_out) begin
        cnt = -1;
        if (spur_en && $urandom_range(0, 15) == 0) begin
          div_ready_in = 1;
          div_result_in = $urandom;
        end
      end else begin
        if (cnt < 0) cnt = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, 8);
        cnt--;
        if (cnt == 0) begin
          div_ready_in = 1;
          real_pulse = 1;
          if (div_divitor_out == 0) div_result_in = 32'hFFFFFFFF;
          else if (div_is_q_out) div_result_in = div_dividend_out % div_divitor_out;
          else div_result_in = div_dividend_out / div_divitor_out;
        end
      end
    end
  end

  // Monitor: compare every accepted result against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid_out && res_ready_in) begin
        if (sb.size() == 0) fail_now("unexpected_result");
        else begin
          e = sb.pop_front();
          check("res_data", res_data_out, e.data);
          check("res_rd", 32'(res_rd_out), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    logic [31:0] held_d;
    logic [4:0]  held_t;
    int g;
    reset_n_in = 0;
`ifdef DIV_SEQ_FLUSH_EN
    flush_in = 0;
`endif
    op_valid_in = 0;
    op_sel_in = 0;
    rs1_in = 0;
    rs2_in = 0;
    rd_in = 0;
    #12;
    check("rst_op_ready", 32'(op_ready_out), 32'h1);
    check("rst_res_valid", 32'(res_valid_out), 32'h0);
    check("rst_busy", 32'(busy_out), 32'h0);
    check("rst_div_req", 32'(div_req_out), 32'h0);
    check("rst_res_data", res_data_out, 32'h0);
    check("rst_dividend", div_dividend_out, 32'h0);
    @(posedge clk); #1;
    reset_n_in = 1;
    repeat (2) begin @(posedge clk); #1; end

    issue(DIVU, 100, 7, 1);
    check("divu_req_on", 32'(div_req_out), 32'h1);
    issue(REMU, 100, 7, 2);
    check("remu_is_q", 32'(div_is_q_out), 32'h1);
    issue(DIV, 32'hFFFFFFF9, 2, 3);
    check("div_neg_req", 32'(div_req_out), 32'h1);
    check("div_neg_dividend", div_dividend_out, 32'h7);
    check("div_neg_divisor", div_divitor_out, 32'h2);
    check("div_neg_is_q", 32'(div_is_q_out), 32'h0);
    issue(REM, 32'hFFFFFFF9, 2, 4);

    special_issue(DIV, 5, 0, 5);
    special_issue(REM, 5, 0, 6);
    special_issue(DIV, 32'h80000000, 32'hFFFFFFFF, 7);
    special_issue(REM, 32'h80000000, 32'hFFFFFFFF, 8);
    wait_idle();

    bp = 1;
    repeat (2) begin @(posedge clk); #1; end
    issue(DIVU, 1000, 3, 9);
    g = 0;
    while (!res_valid_out && g < 100) begin @(posedge clk); #1; g++; end
    if (!res_valid_out) fail_now("bp_wait_valid");
    held_d = res_data_out;
    held_t = res_rd_out;
    check("bp_data", held_d, 32'd333);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 32'(res_valid_out), 32'h1);
      check("bp_data_hold", res_data_out, held_d);
      check("bp_rd_hold", 32'(res_rd_out), 32'(held_t));
      check("bp_op_ready", 32'(op_ready_out), 32'h0);
    end
    bp = 0;
    wait_idle();

    fixed_lat = 30;
    issue(DIVU, 50, 5, 10);
    repeat (3) @(posedge clk);
    #3 reset_n_in = 0;
    #1;
    check("rstmid_req", 32'(div_req_out), 32'h0);
    check("rstmid_busy", 32'(busy_out), 32'h0);
    check("rstmid_valid", 32'(res_valid_out), 32'h0);
    check("rstmid_dividend", div_dividend_out, 32'h0);
    check("rstmid_divisor", div_divitor_out, 32'h0);
    check("rstmid_op_ready", 32'(op_ready_out), 32'h1);
    sb.delete();
    @(posedge clk); #1;
    reset_n_in = 1;
    @(posedge clk); #1;
    fixed_lat = 0;

`ifdef DIV_SEQ_FLUSH_EN
    fixed_lat = 20;
    issue(DIV, 77, 7, 11);
    void'(sb.pop_back());
    repeat (2) begin @(posedge clk); #1; end
    flush_in = 1;
    @(posedge clk); #1;
    flush_in = 0;
    check("flush_busy", 32'(busy_out), 32'h0);
    check("flush_req", 32'(div_req_out), 32'h0);
    check("flush_valid", 32'(res_valid_out), 32'h0);
    fixed_lat = 0;
    issue(DIV, 77, 7, 12);
    wait_idle();
`endif

    issue(DIVU, 100, 7, 13);
    wait_idle();

    spur_en = 1;
    for (int i = 0; i < 300; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_idle();
    spur_en = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
